sync_frame_tx: RTL and testbench

- Serial frame transmitter, the producing end of the serial sync-word link whose far end is the 11011 sequence detector.
- Accepts a parallel payload word via valid/ready, then emits it MSB-first, one bit per clock, on a 1-bit line.
- Each frame is the sync word followed by the payload; the payload may itself contain the sync pattern.
- Drives the detector input directly in system benches.

---
 rtl/sync_frame_pkg.sv | 18 +
 rtl/piso_shifter.sv | 28 ++
 rtl/sync_frame_tx.sv | 128 ++++++++++++
 tb/tb_sync_frame_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the sync-word serial link (transmitter and detector benches).
package sync_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY
    } tx_state_e;

    localparam logic [4:0] DEFAULT_SYNC_WORD = 5'b11011;
    localparam int         DEFAULT_SYNC_LEN  = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shift register: parallel load, shift left, MSB presented on msb.
module piso_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] shreg;

    // A load takes priority so a back-to-back frame can reload on its predecessor's last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= shreg << 1;
        end
    end

    assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word then payload, MSB first, one bit per clock.
// Optional even-parity trailer bit enabled by defining SYNC_FRAME_TX_PARITY_EN.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int                  SYNC_LEN  = DEFAULT_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DEFAULT_SYNC_WORD),
    parameter int                  DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(SYNC_LEN, DATA_W));

    tx_state_e          state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               accept;
    logic               shift_en;
    logic               shift_msb;

    assign accept = data_valid && data_ready;
    assign busy   = (state != IDLE);

    piso_shifter #(
        .DATA_W(DATA_W)
    ) u_shifter (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .shift(shift_en),
        .din  (data_in),
        .msb  (shift_msb)
    );

`ifdef SYNC_FRAME_TX_PARITY_EN
    logic parity_bit;

    // Parity is taken from the word at accept so later data_in changes cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^data_in;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // data_valid is read directly here (never accept) so data_ready has no path from data_valid.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out        = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        data_ready = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    state_next = SYNC;
                    cnt_next   = CNT_W'(SYNC_LEN - 1);
                end
            end
            SYNC: begin
                out       = SYNC_WORD[cnt];
                out_valid = 1'b1;
                if (cnt == '0) begin
                    state_next = DATA;
                    cnt_next   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DATA: begin
                out       = shift_msb;
                out_valid = 1'b1;
                shift_en  = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_next = PARITY;
                    cnt_next   = '0;
`else
                    frame_done = 1'b1;
                    data_ready = 1'b1;
                    state_next = data_valid ? SYNC : IDLE;
                    cnt_next   = data_valid ? CNT_W'(SYNC_LEN - 1) : '0;
`endif
                end
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            PARITY: begin
                out        = parity_bit;
                out_valid  = 1'b1;
                frame_done = 1'b1;
                data_ready = 1'b1;
                state_next = data_valid ? SYNC : IDLE;
                cnt_next   = data_valid ? CNT_W'(SYNC_LEN - 1) : '0;
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Scoreboard bench for sync_frame_tx: expected frame bits are queued at accept and popped by a monitor.
module tb_sync_frame_tx;
    import sync_frame_pkg::*;

    localparam int DATA_W = 8;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int FRAME_LEN = DEFAULT_SYNC_LEN + DATA_W + 1;
`else
    localparam int FRAME_LEN = DEFAULT_SYNC_LEN + DATA_W;
`endif

    typedef struct packed {
        bit b;
        bit last;
    } exp_bit_t;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              out;
    logic              out_valid;
    logic              frame_done;
    logic              busy;

    exp_bit_t exp_q[$];
    bit       cap[$];
    bit       model_ready;
    int       accept_count;
    int       run_len;
    int       max_run;
    int       checks;
    int       failures;

    sync_frame_tx #(
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .out       (out),
        .out_valid (out_valid),
        .frame_done(frame_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference frame: sync word, payload MSB first, optional even parity; last bit flagged.
    task automatic pushFrame(input logic [DATA_W-1:0] w);
        logic [4:0] sw;
        exp_bit_t   e;
        sw = DEFAULT_SYNC_WORD;
        for (int i = DEFAULT_SYNC_LEN - 1; i >= 0; i--) begin
            e.b = sw[i];
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            e.b = bit'((w >> i) & 1);
            e.last = 1'b0;
            exp_q.push_back(e);
        end
`ifdef SYNC_FRAME_TX_PARITY_EN
        e.b = ^w;
        e.last = 1'b0;
        exp_q.push_back(e);
`endif
        exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    // Scoreboard push: a word is taken whenever the model says the line is free for it.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else if (data_valid && model_ready) begin
            pushFrame(data_in);
            accept_count++;
        end
    end

    // Monitor: compare the presented bit against the queue head on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_out", 32'(out), 32'd0);
            checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_data_ready", 32'(data_ready), 32'd1);
            model_ready = 1'b1;
            run_len = 0;
        end else begin
            checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            checkOutput("busy", 32'(busy), 32'(exp_q.size() != 0));
            checkOutput("data_ready", 32'(data_ready), 32'(exp_q.size() <= 1));
            if (exp_q.size() != 0) begin
                checkOutput("out_bit", 32'(out), 32'(exp_q[0].b));
                checkOutput("frame_done", 32'(frame_done), 32'(exp_q[0].last));
            end else begin
                checkOutput("idle_out", 32'(out), 32'd0);
                checkOutput("idle_frame_done", 32'(frame_done), 32'd0);
            end
            model_ready = (exp_q.size() <= 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (out_valid) begin
                cap.push_back(out);
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [DATA_W-1:0] w);
        int start;
        int n;
        start = accept_count;
        n = 0;
        data_in = w;
        data_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (accept_count == start && n < 200);
        if (accept_count == start) begin
            failures++;
            $display("[TB] FAIL accept_timeout: word 0x%0h not taken after %0d cycles", w, n);
        end
        data_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: %0d bits still expected", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] packCap();
        logic [31:0] v;
        v = '0;
        foreach (cap[i]) v = (v << 1) | 32'(cap[i]);
        return v;
    endfunction

    function automatic int countSync();
        logic [4:0] win;
        int n;
        win = '0;
        n = 0;
        foreach (cap[i]) begin
            win = {win[3:0], cap[i]};
            if (i >= 4 && win == DEFAULT_SYNC_WORD) n++;
        end
        return n;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        accept_count = 0;
        model_ready = 1'b1;
        run_len = 0;
        max_run = 0;
        reset = 1'b1;
        data_in = '0;
        data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single frame, 8'hA5
        cap.delete();
        max_run = 0;
        applyStimulus(8'hA5);
        waitDrain();
        checkOutput("a5_len", 32'(cap.size()), 32'(FRAME_LEN));
`ifdef SYNC_FRAME_TX_PARITY_EN
        checkOutput("a5_bits", packCap(), 32'b11011_10100101_0);
`else
        checkOutput("a5_bits", packCap(), 32'b11011_10100101);
`endif
        checkOutput("a5_run", 32'(max_run), 32'(FRAME_LEN));

        // Back-to-back 8'h00 then 8'hFF with no gap
        cap.delete();
        max_run = 0;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        waitDrain();
`ifdef SYNC_FRAME_TX_PARITY_EN
        checkOutput("b2b_bits", packCap(), 32'b11011_00000000_0_11011_11111111_0);
`else
        checkOutput("b2b_bits", packCap(), 32'b11011_00000000_11011_11111111);
`endif
        checkOutput("b2b_run", 32'(max_run), 32'(2 * FRAME_LEN));

        // Payload containing the sync pattern
        cap.delete();
        applyStimulus(8'h1B);
        waitDrain();
        checkOutput("sync_in_payload", 32'(countSync()), 32'd2);

        // Reset during payload bit 2 (frame cycle 7)
        applyStimulus(8'h55);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_out", 32'(out), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ready", 32'(data_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cap.delete();
        applyStimulus(8'h3C);
        waitDrain();
`ifdef SYNC_FRAME_TX_PARITY_EN
        checkOutput("post_rst_bits", packCap(), 32'b11011_00111100_0);
`else
        checkOutput("post_rst_bits", packCap(), 32'b11011_00111100);
`endif

        // data_in changes after accept are ignored
        cap.delete();
        applyStimulus(8'hF0);
        @(posedge clk);
        #1;
        data_in = 8'h0F;
        waitDrain();
`ifdef SYNC_FRAME_TX_PARITY_EN
        checkOutput("hold_bits", packCap(), 32'b11011_11110000_0);
`else
        checkOutput("hold_bits", packCap(), 32'b11011_11110000);
`endif

`ifdef SYNC_FRAME_TX_PARITY_EN
        cap.delete();
        applyStimulus(8'h07);
        waitDrain();
        checkOutput("parity_len", 32'(cap.size()), 32'd14);
        checkOutput("parity_bits", packCap(), 32'b11011_00000111_1);
`endif

        // Randomized words with random gaps and random mid-frame data_in noise
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            applyStimulus(DATA_W'($urandom));
            data_in = DATA_W'($urandom);
        end
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
